// File: rtl/bitstream_pkg.sv
// Shared types and defaults for the stochastic bitstream decoder.
package bitstream_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, HOLD} dec_state_t;

  localparam int unsigned DEC_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bitstream_decoder_if.sv
// Bitstream input, start request and valid/ready result port of the decoder.
interface bitstream_decoder_if
  import bitstream_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_WIDTH_DEFAULT
);
  logic             x;
  logic             start;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] value;

  // Producer of the stream and consumer of the result.
  modport master (output x, start, ready, input busy, valid, value);
  // The decoder itself.
  modport slave  (input x, start, ready, output busy, valid, value);
endinterface

// File: rtl/bitstream_window_counter.sv
// Ones accumulator for one count window. sat_count is the saturated total
// including the bit currently on x, so the owner can capture the final
// result on the same edge that takes the last sample.
module bitstream_window_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             en,
  input  logic             x,
  output logic [WIDTH-1:0] sat_count
);

  logic [WIDTH:0] acc_q;
  logic [WIDTH:0] sum;

  // Accumulate sampled ones; clear has priority so a restart never mixes windows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + {{WIDTH{1'b0}}, x};
    end
  end

  // A full window of ones gives exactly 2**WIDTH, the only value with the top bit set.
  always_comb begin
    sum       = acc_q + {{WIDTH{1'b0}}, x};
    sat_count = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

endmodule

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream to binary decoder: skip SKIP settle cycles, count ones
// over 2**WIDTH cycles, then hold the saturated count on a valid/ready port.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int unsigned WIDTH = DEC_WIDTH_DEFAULT,
  parameter int unsigned SKIP  = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  bitstream_decoder_if.slave bus
);

  // Terminal values of the shared cycle counter; neither state lets it wrap.
  localparam logic [WIDTH:0] SettleLast = (WIDTH+1)'((SKIP == 0) ? 0 : SKIP - 1);
  localparam logic [WIDTH:0] CountLast  = (WIDTH+1)'((2 ** WIDTH) - 1);

  dec_state_t       state_q, state_d;
  logic [WIDTH:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             acc_clear;
  logic             acc_en;
  logic             launch;
  logic [WIDTH-1:0] sat_count;

  bitstream_window_counter #(
    .WIDTH (WIDTH)
  ) u_window_counter (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (acc_clear),
    .en        (acc_en),
    .x         (bus.x),
    .sat_count (sat_count)
  );

  // State, counter and registered outputs; reset aborts any conversion.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE or on an accepting HOLD edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    launch    = 1'b0;

    unique case (state_q)
      IDLE: begin
        launch = bus.start;
      end
      SETTLE: begin
        if (cnt_q == SettleLast) begin
          cnt_d   = '0;
          state_d = COUNT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      COUNT: begin
        acc_en = 1'b1;
        if (cnt_q == CountLast) begin
          value_d = sat_count;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (valid_q && bus.ready) begin
          valid_d = 1'b0;
          if (bus.start) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Back-to-back start from HOLD reuses this path, so there is no idle bubble.
    if (launch) begin
      cnt_d     = '0;
      acc_clear = 1'b1;
      busy_d    = 1'b1;
      state_d   = (SKIP == 0) ? COUNT : SETTLE;
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Randomised self-checking bench for bitstream_decoder (WIDTH=8; SKIP=16 and SKIP=0).
module tb_bitstream_decoder;
  import bitstream_pkg::*;

  localparam int unsigned W    = 8;
  localparam int unsigned Win  = 2 ** W;
  localparam int unsigned Skip = 16;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  bitstream_decoder_if #(.WIDTH(W)) bus  ();
  bitstream_decoder_if #(.WIDTH(W)) bus0 ();

  bitstream_decoder #(.WIDTH(W), .SKIP(Skip)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  bitstream_decoder #(.WIDTH(W), .SKIP(0)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic x, input logic st, input logic rdy);
    if (sel) begin
      bus0.x = x; bus0.start = st; bus0.ready = rdy;
    end else begin
      bus.x = x; bus.start = st; bus.ready = rdy;
    end
  endtask

  task automatic peek(input bit sel, output logic busy, output logic valid,
                      output logic [W-1:0] value);
    if (sel) begin
      busy = bus0.busy; valid = bus0.valid; value = bus0.value;
    end else begin
      busy = bus.busy; valid = bus.valid; value = bus.value;
    end
  endtask

  // Builds the whole input stream up front, derives the expected count from
  // the window portion, then plays it and checks the exact result edge.
  // mode: 0 zeros, 1 ones, 2 settle ones then 1010.., 3 random, 4 generator.
  task automatic convert(input bit sel, input int mode, input bit pre, input bit poke,
                         input string tag, output logic [W-1:0] exp);
    int unsigned skip;
    int unsigned n;
    int unsigned ones;
    logic        bits[$];
    logic        b;
    logic [7:0]  lfsr;
    logic        busy, valid;
    logic [W-1:0] value;
    skip = sel ? 0 : Skip;
    n    = skip + Win;
    ones = 0;
    lfsr = 8'b1010100;
    for (int k = 1; k <= int'(n); k++) begin
      case (mode)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (k <= int'(skip)) ? 1'b1 : ((k - int'(skip) - 1) % 2 == 0);
        3: b = 1'($urandom_range(0, 1));
        default: begin
          b    = (lfsr < 8'd5);
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
      endcase
      bits.push_back(b);
      if (k > int'(skip)) ones += int'(b);
    end
    exp = (ones >= Win) ? W'(Win - 1) : W'(ones);

    if (!pre) begin
      drive(sel, 1'b0, 1'b1, 1'b0);
      step();
    end
    for (int k = 1; k <= int'(n); k++) begin
      drive(sel, bits[k-1], poke ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
      step();
      peek(sel, busy, valid, value);
      if (k == int'(skip / 2) + 1) check_eq({tag, "_busy_mid"}, 32'(busy), 32'd1);
      if (k == int'(n) - 1) check_eq({tag, "_valid_early"}, 32'(valid), 32'd0);
    end
    peek(sel, busy, valid, value);
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq({tag, "_value"}, 32'(value), 32'(exp));
    check_eq({tag, "_busy_hold"}, 32'(busy), 32'd0);
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic accept(input bit sel, input logic [W-1:0] exp, input string tag);
    logic busy, valid;
    logic [W-1:0] value;
    drive(sel, 1'b0, 1'b0, 1'b1);
    step();
    peek(sel, busy, valid, value);
    check_eq({tag, "_acc_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_acc_value"}, 32'(value), 32'(exp));
    check_eq({tag, "_acc_busy"}, 32'(busy), 32'd0);
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] exp;
    logic busy, valid;
    logic [W-1:0] value;

    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #12;
    for (int s = 0; s < 2; s++) begin
      peek(s[0], busy, valid, value);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_value", 32'(value), 32'd0);
    end
    n_rst = 1'b1;
    step();

    // All zeros, then all ones on both SKIP settings.
    convert(1'b0, 0, 1'b0, 1'b0, "zeros", exp);
    accept(1'b0, exp, "zeros");
    convert(1'b0, 1, 1'b0, 1'b0, "ones", exp);
    accept(1'b0, exp, "ones");
    convert(1'b1, 1, 1'b0, 1'b0, "ones_skip0", exp);
    accept(1'b1, exp, "ones_skip0");

    // Settle ones excluded; result then held under start/x noise without ready.
    convert(1'b0, 2, 1'b0, 1'b0, "alt", exp);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      step();
      peek(1'b0, busy, valid, value);
      check_eq("hold_valid", 32'(valid), 32'd1);
      check_eq("hold_value", 32'(value), 32'(exp));
    end
    // Accept and restart on the same edge.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    peek(1'b0, busy, valid, value);
    check_eq("b2b_valid", 32'(valid), 32'd0);
    check_eq("b2b_busy", 32'(busy), 32'd1);
    convert(1'b0, 3, 1'b1, 1'b1, "rand_poke", exp);
    accept(1'b0, exp, "rand_poke");

    // Reset mid-COUNT: outputs clear without waiting for a clock edge.
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step();
    #2 n_rst = 1'b0;
    #1;
    peek(1'b0, busy, valid, value);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_value", 32'(value), 32'd0);
    #1 n_rst = 1'b1;
    step();
    convert(1'b0, 1, 1'b0, 1'b0, "ones_after_rst", exp);
    accept(1'b0, exp, "ones_after_rst");

    // Generator stream, plus a few random windows.
    convert(1'b0, 4, 1'b0, 1'b0, "gen", exp);
    accept(1'b0, exp, "gen");
    for (int r = 0; r < 3; r++) begin
      convert(1'b0, 3, 1'b0, 1'b1, "rand", exp);
      accept(1'b0, exp, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
